// File: rtl/mem_fetch_unit_if.sv
// Memory bus between the fetch/data sequencer (master) and the shared memory (slave).
// A transfer completes on any rising edge where mem_valid and mem_ready are both high.
interface mem_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int BUS_W  = 8
);
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_adr;
  logic              mem_we;
  logic [BUS_W-1:0]  mem_wd;
  logic [BUS_W-1:0]  mem_rd;
  logic              mem_ready;

  modport master (
    output mem_valid, mem_adr, mem_we, mem_wd,
    input  mem_rd, mem_ready
  );

  modport slave (
    input  mem_valid, mem_adr, mem_we, mem_wd,
    output mem_rd, mem_ready
  );
endinterface

// File: rtl/mem_fetch_unit.sv
// Handshaked memory sequencer: multi-beat instruction fetch plus single-beat data load/store,
// with an optional data-then-fetch sequence when both requests arrive together.
module mem_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int BUS_W   = 8,
  parameter int INSTR_W = 16
) (
  input  logic               ph1,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               data_req,
  input  logic               data_we,
  input  logic [ADDR_W-1:0]  data_adr,
  input  logic [BUS_W-1:0]   data_wd,
  output logic               busy,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [BUS_W-1:0]   data_rd,
  output logic               data_done,
  mem_fetch_unit_if.master   mem
);

  localparam int BEATS  = INSTR_W / BUS_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                pend_fetch_q, pend_fetch_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   data_adr_q, data_adr_d;
  logic                data_we_q, data_we_d;
  logic [BUS_W-1:0]    data_wd_q, data_wd_d;
  logic [INSTR_W-1:0]  shift_q, shift_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic [BUS_W-1:0]    data_rd_q, data_rd_d;
  logic                data_done_q, data_done_d;
  logic                mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]   mem_adr_q, mem_adr_d;
  logic                mem_we_q, mem_we_d;
  logic [BUS_W-1:0]    mem_wd_q, mem_wd_d;
  logic                xfer;

  // Next-state, capture and registered bus-output computation
  always_comb begin
    state_d       = state_q;
    pend_fetch_d  = pend_fetch_q;
    beat_d        = beat_q;
    pc_d          = pc_q;
    data_adr_d    = data_adr_q;
    data_we_d     = data_we_q;
    data_wd_d     = data_wd_q;
    shift_d       = shift_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    data_rd_d     = data_rd_q;
    data_done_d   = 1'b0;
    xfer          = mem_valid_q & mem.mem_ready;

    case (state_q)
      IDLE: begin
        if (fetch_req) begin
          pc_d = pc;
        end else begin
          pc_d = pc_q;
        end
        if (data_req) begin
          data_adr_d   = data_adr;
          data_we_d    = data_we;
          data_wd_d    = data_wd;
          pend_fetch_d = fetch_req;
          state_d      = DATA;
        end else if (fetch_req) begin
          beat_d  = '0;
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (xfer) begin
          if (!data_we_q) begin
            data_rd_d = mem.mem_rd;
          end else begin
            data_rd_d = data_rd_q;
          end
          data_done_d = 1'b1;
          if (pend_fetch_q) begin
            // Combined request: fetch starts in the same cycle data_done pulses
            pend_fetch_d = 1'b0;
            beat_d       = '0;
            state_d      = FETCH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = DATA;
        end
      end
      FETCH: begin
        if (xfer) begin
          shift_d = (shift_q << BUS_W) | INSTR_W'(mem.mem_rd);
          if (beat_q == LAST_BEAT) begin
            instr_d       = shift_d;
            instr_valid_d = 1'b1;
            beat_d        = '0;
            state_d       = IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mem_valid_d = (state_d != IDLE);
    case (state_d)
      DATA: begin
        mem_adr_d = data_adr_d;
        mem_we_d  = data_we_d;
        mem_wd_d  = data_we_d ? data_wd_d : '0;
      end
      FETCH: begin
        mem_adr_d = pc_d + ADDR_W'(beat_d);
        mem_we_d  = 1'b0;
        mem_wd_d  = '0;
      end
      default: begin
        mem_adr_d = '0;
        mem_we_d  = 1'b0;
        mem_wd_d  = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge ph1) begin
    if (reset) begin
      state_q       <= IDLE;
      pend_fetch_q  <= 1'b0;
      beat_q        <= '0;
      pc_q          <= '0;
      data_adr_q    <= '0;
      data_we_q     <= 1'b0;
      data_wd_q     <= '0;
      shift_q       <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      data_rd_q     <= '0;
      data_done_q   <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_adr_q     <= '0;
      mem_we_q      <= 1'b0;
      mem_wd_q      <= '0;
    end else begin
      state_q       <= state_d;
      pend_fetch_q  <= pend_fetch_d;
      beat_q        <= beat_d;
      pc_q          <= pc_d;
      data_adr_q    <= data_adr_d;
      data_we_q     <= data_we_d;
      data_wd_q     <= data_wd_d;
      shift_q       <= shift_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      data_rd_q     <= data_rd_d;
      data_done_q   <= data_done_d;
      mem_valid_q   <= mem_valid_d;
      mem_adr_q     <= mem_adr_d;
      mem_we_q      <= mem_we_d;
      mem_wd_q      <= mem_wd_d;
    end
  end

  assign busy          = mem_valid_q;
  assign instr         = instr_q;
  assign instr_valid   = instr_valid_q;
  assign data_rd       = data_rd_q;
  assign data_done     = data_done_q;
  assign mem.mem_valid = mem_valid_q;
  assign mem.mem_adr   = mem_adr_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_wd    = mem_wd_q;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Directed bench for mem_fetch_unit: inputs change 1 time unit after the rising edge
// and outputs are sampled at that same point, one sample per cycle.
module tb_mem_fetch_unit;

  logic        ph1 = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [7:0]  pc;
  logic        data_req;
  logic        data_we;
  logic [7:0]  data_adr;
  logic [7:0]  data_wd;
  logic        busy;
  logic [15:0] instr;
  logic        instr_valid;
  logic [7:0]  data_rd;
  logic        data_done;
  logic        mem_ready_tb;
  logic [7:0]  mem_model [256];

  int n_checks = 0;
  int n_pass   = 0;

  mem_fetch_unit_if #(.ADDR_W(8), .BUS_W(8)) mem_if ();

  mem_fetch_unit #(.ADDR_W(8), .BUS_W(8), .INSTR_W(16)) dut (
    .ph1         (ph1),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .pc          (pc),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_adr    (data_adr),
    .data_wd     (data_wd),
    .busy        (busy),
    .instr       (instr),
    .instr_valid (instr_valid),
    .data_rd     (data_rd),
    .data_done   (data_done),
    .mem         (mem_if)
  );

  assign mem_if.mem_ready = mem_ready_tb;
  assign mem_if.mem_rd    = mem_model[mem_if.mem_adr];

  always #5 ph1 = ~ph1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge ph1);
    #1;
  endtask

  task automatic clear_req();
    fetch_req = 1'b0;
    data_req  = 1'b0;
    data_we   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    mem_model[8'h10] = 8'hA5;
    mem_model[8'h11] = 8'h3C;
    mem_model[8'hFF] = 8'h12;
    mem_model[8'h00] = 8'h34;
    mem_model[8'h20] = 8'h77;
    mem_model[8'h21] = 8'h88;
    mem_model[8'h40] = 8'hC3;

    reset = 1'b1; clear_req();
    pc = 8'h00; data_adr = 8'h00; data_wd = 8'h00; mem_ready_tb = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    check_eq("rst_busy",      busy,             32'd0);
    check_eq("rst_instr",     instr,            32'd0);
    check_eq("rst_mem_valid", mem_if.mem_valid, 32'd0);
    check_eq("rst_mem_adr",   mem_if.mem_adr,   32'd0);

    // Basic fetch at 0x10
    fetch_req = 1'b1; pc = 8'h10;
    step(); clear_req();
    check_eq("bf_n1_valid", mem_if.mem_valid, 32'd1);
    check_eq("bf_n1_adr",   mem_if.mem_adr,   32'h10);
    check_eq("bf_n1_we",    mem_if.mem_we,    32'd0);
    check_eq("bf_n1_iv",    instr_valid,      32'd0);
    step();
    check_eq("bf_n2_adr",   mem_if.mem_adr,   32'h11);
    check_eq("bf_n2_iv",    instr_valid,      32'd0);
    step();
    check_eq("bf_n3_iv",    instr_valid,      32'd1);
    check_eq("bf_n3_instr", instr,            32'hA53C);
    check_eq("bf_n3_valid", mem_if.mem_valid, 32'd0);
    step();
    check_eq("bf_n4_iv",    instr_valid,      32'd0);

    // Address wrap at 0xFF
    fetch_req = 1'b1; pc = 8'hFF;
    step(); clear_req();
    check_eq("wr_n1_adr",   mem_if.mem_adr, 32'hFF);
    step();
    check_eq("wr_n2_adr",   mem_if.mem_adr, 32'h00);
    step();
    check_eq("wr_n3_iv",    instr_valid,    32'd1);
    check_eq("wr_n3_instr", instr,          32'h1234);
    step();

    // Wait states: mem_ready low for 3 cycles on beat 0
    fetch_req = 1'b1; pc = 8'h10; mem_ready_tb = 1'b0;
    step(); clear_req();
    for (int c = 1; c <= 3; c++) begin
      check_eq($sformatf("ws_n%0d_adr", c),   mem_if.mem_adr,   32'h10);
      check_eq($sformatf("ws_n%0d_valid", c), mem_if.mem_valid, 32'd1);
      if (c < 3) step();
    end
    step(); mem_ready_tb = 1'b1;
    check_eq("ws_n4_adr",   mem_if.mem_adr, 32'h10);
    step();
    check_eq("ws_n5_adr",   mem_if.mem_adr, 32'h11);
    check_eq("ws_n5_iv",    instr_valid,    32'd0);
    step();
    check_eq("ws_n6_iv",    instr_valid,    32'd1);
    check_eq("ws_n6_instr", instr,          32'hA53C);
    step();

    // Combined store + fetch
    fetch_req = 1'b1; pc = 8'h20;
    data_req = 1'b1; data_we = 1'b1; data_adr = 8'h80; data_wd = 8'h5A;
    step(); clear_req();
    check_eq("cb_n1_we",    mem_if.mem_we,  32'd1);
    check_eq("cb_n1_adr",   mem_if.mem_adr, 32'h80);
    check_eq("cb_n1_wd",    mem_if.mem_wd,  32'h5A);
    check_eq("cb_n1_dd",    data_done,      32'd0);
    step();
    check_eq("cb_n2_dd",    data_done,      32'd1);
    check_eq("cb_n2_we",    mem_if.mem_we,  32'd0);
    check_eq("cb_n2_adr",   mem_if.mem_adr, 32'h20);
    check_eq("cb_n2_wd",    mem_if.mem_wd,  32'h00);
    step();
    check_eq("cb_n3_adr",   mem_if.mem_adr, 32'h21);
    check_eq("cb_n3_dd",    data_done,      32'd0);
    step();
    check_eq("cb_n4_iv",    instr_valid,    32'd1);
    check_eq("cb_n4_instr", instr,          32'h7788);
    check_eq("cb_n4_rd",    data_rd,        32'h00);
    step();

    // Request while busy is dropped; request in the instr_valid cycle is taken
    fetch_req = 1'b1; pc = 8'h10;
    step(); clear_req();
    data_req = 1'b1; data_we = 1'b0; data_adr = 8'h40;
    check_eq("rb_n1_adr", mem_if.mem_adr, 32'h10);
    step(); clear_req();
    check_eq("rb_n2_adr", mem_if.mem_adr, 32'h11);
    check_eq("rb_n2_we",  mem_if.mem_we,  32'd0);
    step();
    check_eq("rb_n3_iv",  instr_valid,    32'd1);
    data_req = 1'b1; data_we = 1'b0; data_adr = 8'h40;
    step(); clear_req();
    check_eq("rb_n4_valid", mem_if.mem_valid, 32'd1);
    check_eq("rb_n4_adr",   mem_if.mem_adr,   32'h40);
    check_eq("rb_n4_we",    mem_if.mem_we,    32'd0);
    check_eq("rb_n4_dd",    data_done,        32'd0);
    step();
    check_eq("rb_n5_dd",    data_done,        32'd1);
    check_eq("rb_n5_rd",    data_rd,          32'hC3);
    step();
    check_eq("rb_n6_busy",  busy,             32'd0);
    check_eq("rb_n6_dd",    data_done,        32'd0);

    // Reset abort during beat 1 with mem_ready low
    fetch_req = 1'b1; pc = 8'h10;
    step(); clear_req();
    step();
    check_eq("ra_beat1_adr", mem_if.mem_adr, 32'h11);
    mem_ready_tb = 1'b0; reset = 1'b1;
    step();
    check_eq("ra_r1_busy",  busy,             32'd0);
    check_eq("ra_r1_valid", mem_if.mem_valid, 32'd0);
    check_eq("ra_r1_adr",   mem_if.mem_adr,   32'd0);
    check_eq("ra_r1_instr", instr,            32'd0);
    check_eq("ra_r1_rd",    data_rd,          32'd0);
    check_eq("ra_r1_iv",    instr_valid,      32'd0);
    step();
    reset = 1'b0; mem_ready_tb = 1'b1;
    check_eq("ra_r2_busy",  busy,             32'd0);
    check_eq("ra_r2_iv",    instr_valid,      32'd0);
    step();
    check_eq("ra_r3_iv",    instr_valid,      32'd0);
    check_eq("ra_r3_busy",  busy,             32'd0);
    check_eq("ra_r3_we",    mem_if.mem_we,    32'd0);
    check_eq("ra_r3_wd",    mem_if.mem_wd,    32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_fetch_unit.md
# mem_fetch_unit

Parametrised memory sequencer sitting between the processor core and the single shared memory bus. It replaces the fixed two-state fetch/load-store cycle with a handshaked FSM. The FSM assembles an INSTR_W-bit instruction from several BUS_W-wide beats, performs single-beat data loads and stores, and tolerates memory wait states through a valid/ready handshake. The core issues one-cycle requests and receives one-cycle completion pulses.

## Interface
- ADDR_W, 8, memory address width
- BUS_W, 8, memory data bus width
- INSTR_W, 16, instruction width; must be an integer multiple of BUS_W; BEATS = INSTR_W/BUS_W (≥1)
- ph1  input  1  clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- fetch_req  input  1  one-cycle request: fetch instruction at pc
- pc  input  ADDR_W  instruction address, captured with fetch_req
- data_req  input  1  one-cycle request: data access
- data_we  input  1  1 = store, 0 = load; captured with data_req
- data_adr  input  ADDR_W  data address, captured with data_req
- data_wd  input  BUS_W  store data, captured with data_req
- busy  output  1  unit is executing an accepted request
- instr  output  INSTR_W  last completed instruction
- instr_valid  output  1  one-cycle pulse: instr updated
- data_rd  output  BUS_W  last completed load data
- data_done  output  1  one-cycle pulse: data access complete
- mem_valid  output  1  bus transfer requested
- mem_adr  output  ADDR_W  bus address
- mem_we  output  1  bus write strobe
- mem_wd  output  BUS_W  bus write data
- mem_rd  input  BUS_W  bus read data, valid when mem_valid & mem_ready
- mem_ready  input  1  memory accepts/completes transfer this cycle

## Operation
- FSM states: IDLE, DATA, FETCH.
- Requests are accepted only in IDLE with reset low. Requests seen while busy=1 are ignored and are not queued.
- Accepting fetch_req alone moves the FSM to FETCH. Accepting data_req alone moves it to DATA.
- When fetch_req and data_req are accepted together, both are captured. The FSM enters DATA first and sets a pending-fetch flag. After the data transfer completes, it goes directly to FETCH.
- A transfer completes on an edge where mem_valid & mem_ready are both 1. mem_adr, mem_we and mem_wd are held stable while mem_ready=0.
- DATA state:
  - mem_adr = data_adr.
  - Store: mem_we = 1 and mem_wd = data_wd.
  - Load: mem_we = 0 and mem_rd is captured into data_rd on completion.
  - A store leaves data_rd unchanged.
- FETCH state:
  - Beat k (0..BEATS-1) uses mem_adr = pc + k modulo 2^ADDR_W (the address wraps).
  - Beat 0 fills the most-significant BUS_W bits.
  - The beat counter advances only on a completed transfer.
  - Beats are assembled in an internal shift register. instr is updated only after the final beat, so partial fetches are never visible.
  - mem_we = 0 and mem_wd = 0 throughout.
- mem_valid = 1 exactly while the FSM is in DATA or FETCH.
- busy = mem_valid.
- After the final transfer the FSM returns to IDLE. instr_valid or data_done pulses high in the next cycle, and a new request may be accepted in that same pulse cycle.

## Timing
- Cycle N is the cycle in which a request is high with busy=0. All cycle numbers below assume mem_ready=1 (zero wait states).
- Fetch only:
  - mem_valid is high in cycles N+1..N+BEATS.
  - instr_valid is high in cycle N+BEATS+1.
- Data only:
  - mem_valid is high in cycle N+1.
  - data_done is high in cycle N+2.
- Data and fetch together:
  - Data transfer in cycle N+1.
  - data_done and the first fetch beat both in cycle N+2.
  - instr_valid in cycle N+BEATS+2.
- Each cycle with mem_ready=0 during a transfer adds one cycle to every subsequent event.
- Reset behaviour:
  - Reset at any edge (including mid-transfer or mid-fetch) forces IDLE and clears the pending flag and beat counter.
  - From the following cycle, every output is 0: busy, instr, instr_valid, data_rd, data_done, mem_valid, mem_adr, mem_we, mem_wd.
  - An aborted operation produces no completion pulse.

## Test plan
- **Reset abort:** assert reset for 2 cycles during beat 1 of a fetch with mem_ready=0 → all outputs 0 from the cycle after the first reset edge; no instr_valid; busy=0.
- **Basic fetch:** pc=0x10; memory returns 0xA5 @0x10 and 0x3C @0x11; mem_ready=1 → mem_adr 0x10 then 0x11; instr=0xA53C with instr_valid high at N+3 only.
- **Address wrap:** pc=0xFF; memory returns 0x12 @0xFF and 0x34 @0x00 → mem_adr 0xFF then 0x00; instr=0x1234.
- **Wait states:** hold mem_ready=0 for 3 cycles on beat 0 of a fetch at pc=0x10 → mem_adr stays 0x10 and mem_valid stays 1; instr_valid at N+6.
- **Combined request:** fetch_req pc=0x20 and data_req store (data_adr=0x80, data_wd=0x5A) in the same cycle → mem_we=1 for exactly one cycle with mem_adr=0x80 and mem_wd=0x5A; data_done at N+2; instr_valid at N+4; data_rd unchanged.
- **Request while busy:** data_req load issued at N+1 during a fetch is ignored (no extra transfer). A load at 0x40 (memory value 0xC3) issued in the instr_valid cycle is accepted → data_rd=0xC3 with data_done two cycles later.
